// File: rtl/cnna_udiv_22ns_9ns_13_seq.sv
// Sequential restoring divider, 22-bit dividend by 9-bit divisor.
// One quotient bit per cycle with valid/ready handshakes on both sides.
module cnna_udiv_22ns_9ns_13_seq #(
  parameter logic [31:0] ID             = 32'd1,
  parameter int          DIVIDEND_WIDTH = 22,
  parameter int          DIVISOR_WIDTH  = 9,
  parameter int          QUOTIENT_WIDTH = 13
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [QUOTIENT_WIDTH-1:0] dout,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      ovf,
  output logic                      dbz,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(QW);

  if (QW != DW - VW) begin : g_width_check
    $error("QUOTIENT_WIDTH must equal DIVIDEND_WIDTH - DIVISOR_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [VW-1:0]   divisor_q, divisor_d;
  logic [QW-1:0]   sr_q, sr_d;
  logic [VW-1:0]   r_q, r_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_p_q, ovf_p_d;
  logic            dbz_p_q, dbz_p_d;
  logic [QW-1:0]   dout_q, dout_d;
  logic [VW-1:0]   rem_q, rem_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;

  logic [VW:0]     trial;
  logic [VW:0]     diff;
  logic            ge;
  logic [VW-1:0]   r_next;
  logic [QW-1:0]   quo_next;
  logic            unused_id;

  assign unused_id = ^ID;

  assign trial    = {r_q, sr_q[QW-1]};
  assign diff     = trial - {1'b0, divisor_q};
  assign ge       = trial >= {1'b0, divisor_q};
  assign r_next   = ge ? diff[VW-1:0] : trial[VW-1:0];
  assign quo_next = {quo_q[QW-2:0], ge};

  always_comb begin
    state_d   = state_q;
    divisor_d = divisor_q;
    sr_d      = sr_q;
    r_d       = r_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    ovf_p_d   = ovf_p_q;
    dbz_p_d   = dbz_p_q;
    dout_d    = dout_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          divisor_d = din1;
          sr_d      = din0[QW-1:0];
          r_d       = din0[DW-1:QW];
          quo_d     = '0;
          cnt_d     = CW'(QW - 1);
          dbz_p_d   = (din1 == '0);
          ovf_p_d   = (din1 != '0) && (din0[DW-1:QW] >= din1);
          state_d   = CALC;
        end
      end
      CALC: begin
        // Error operands spend a single cycle here before reporting
        if (dbz_p_q || ovf_p_q) begin
          dout_d  = '1;
          rem_d   = '0;
          dbz_d   = dbz_p_q;
          ovf_d   = ovf_p_q;
          state_d = DONE;
        end else begin
          r_d   = r_next;
          quo_d = quo_next;
          sr_d  = {sr_q[QW-2:0], 1'b0};
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            dout_d  = quo_next;
            rem_d   = r_next;
            ovf_d   = 1'b0;
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      sr_q      <= '0;
      r_q       <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      ovf_p_q   <= 1'b0;
      dbz_p_q   <= 1'b0;
      dout_q    <= '0;
      rem_q     <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      divisor_q <= divisor_d;
      sr_q      <= sr_d;
      r_q       <= r_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      ovf_p_q   <= ovf_p_d;
      dbz_p_q   <= dbz_p_d;
      dout_q    <= dout_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = dout_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_cnna_udiv_22ns_9ns_13_seq.sv
// Directed and swept checks for the sequential 22/9 divider.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cnna_udiv_22ns_9ns_13_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic [21:0] din0 = '0;
  logic [8:0]  din1 = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [12:0] dout;
  logic [8:0]  rem;
  logic        ovf;
  logic        dbz;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  cnna_udiv_22ns_9ns_13_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .din0      (din0),
    .din1      (din1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  // Issue one operand pair and wait (bounded) for out_valid.
  task automatic start_op(input logic [21:0] a, input logic [8:0] b,
                          output int lat);
    @(negedge ap_clk);
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    din0 = 22'h2AAAAA;
    din1 = 9'h155;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge ap_clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 ap_rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (dout !== 13'd0 || rem !== 9'd0 || ovf !== 1'b0 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL reset_out got dout=%0d rem=%0d ovf=%b dbz=%b want 0",
               dout, rem, ovf, dbz);
    end
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    start_op(22'd1000, 9'd7, lat);
    checks++;
    if (lat !== 13) begin
      failures++;
      $display("FAIL basic_latency got %0d want 13", lat);
    end
    checks++;
    if (dout !== 13'd142 || rem !== 9'd6 || ovf !== 1'b0 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL basic_1000_7 got dout=%0d rem=%0d ovf=%b dbz=%b want 142 6 0 0",
               dout, rem, ovf, dbz);
    end
    consume();
  endtask

  task automatic test_max_quotient();
    int lat;
    start_op(22'd4186111, 9'd511, lat);
    checks++;
    if (lat !== 13) begin
      failures++;
      $display("FAIL maxq_latency got %0d want 13", lat);
    end
    checks++;
    if (dout !== 13'd8191 || rem !== 9'd510 || ovf !== 1'b0 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL maxq got dout=%0d rem=%0d ovf=%b dbz=%b want 8191 510 0 0",
               dout, rem, ovf, dbz);
    end
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    start_op(22'd4194303, 9'd511, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL ovf_latency got %0d want 1", lat);
    end
    checks++;
    if (dout !== 13'd8191 || rem !== 9'd0 || ovf !== 1'b1 || dbz !== 1'b0) begin
      failures++;
      $display("FAIL ovf got dout=%0d rem=%0d ovf=%b dbz=%b want 8191 0 1 0",
               dout, rem, ovf, dbz);
    end
    consume();
  endtask

  task automatic test_div_by_zero();
    int lat;
    start_op(22'd1234, 9'd0, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL dbz_latency got %0d want 1", lat);
    end
    checks++;
    if (dout !== 13'd8191 || rem !== 9'd0 || ovf !== 1'b0 || dbz !== 1'b1) begin
      failures++;
      $display("FAIL dbz got dout=%0d rem=%0d ovf=%b dbz=%b want 8191 0 0 1",
               dout, rem, ovf, dbz);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(22'd100, 9'd3, lat);
    checks++;
    if (lat !== 13) begin
      failures++;
      $display("FAIL hold_latency got %0d want 13", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dout !== 13'd33 || rem !== 9'd1 || in_ready !== 1'b0 ||
          out_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold_c%0d got dout=%0d rem=%0d in_ready=%b out_valid=%b want 33 1 0 1",
                 i, dout, rem, in_ready, out_valid);
      end
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (dout !== 13'd33 || rem !== 9'd1) begin
      failures++;
      $display("FAIL idle_hold got dout=%0d rem=%0d want 33 1", dout, rem);
    end
    start_op(22'd200, 9'd9, lat);
    checks++;
    if (lat !== 13 || dout !== 13'd22 || rem !== 9'd2 || ovf !== 1'b0 ||
        dbz !== 1'b0) begin
      failures++;
      $display("FAIL b2b_200_9 got lat=%0d dout=%0d rem=%0d ovf=%b dbz=%b want 13 22 2 0 0",
               lat, dout, rem, ovf, dbz);
    end
    consume();
  endtask

  task automatic test_async_reset();
    int lat;
    int seen;
    @(negedge ap_clk);
    din0 = 22'd1000;
    din1 = 9'd7;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL calc_hs got in_ready=%b out_valid=%b want 0 0",
               in_ready, out_valid);
    end
    repeat (6) @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    checks++;
    if (dout !== 13'd0 || rem !== 9'd0 || in_ready !== 1'b1 ||
        out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got dout=%0d rem=%0d in_ready=%b out_valid=%b want 0 0 1 0",
               dout, rem, in_ready, out_valid);
    end
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL no_stale_valid got %0d valid cycles want 0", seen);
    end
    start_op(22'd1000, 9'd7, lat);
    checks++;
    if (lat !== 13 || dout !== 13'd142 || rem !== 9'd6) begin
      failures++;
      $display("FAIL post_rst_1000_7 got lat=%0d dout=%0d rem=%0d want 13 142 6",
               lat, dout, rem);
    end
    consume();
  endtask

  task automatic test_sweep();
    int lat;
    logic [21:0] a;
    logic [8:0]  b;
    logic [8:0]  hi;
    logic        err;
    int          recon;
    for (int i = 0; i < 3000; i++) begin
      b = 9'($urandom_range(0, 511));
      if (i % 200 == 0) b = 9'd0;
      if ($urandom_range(0, 7) == 0 || b == 9'd0) begin
        a = 22'($urandom);
      end else begin
        hi = 9'($urandom_range(0, int'(b) - 1));
        a = {hi, 13'($urandom)};
      end
      err = (b == 9'd0) || (a[21:13] >= b);
      start_op(a, b, lat);
      checks++;
      if (lat !== (err ? 1 : 13)) begin
        failures++;
        $display("FAIL sweep_lat a=%0d b=%0d got %0d want %0d",
                 a, b, lat, err ? 1 : 13);
      end
      if (b == 9'd0) begin
        checks++;
        if (dbz !== 1'b1 || ovf !== 1'b0 || dout !== 13'h1FFF || rem !== 9'd0) begin
          failures++;
          $display("FAIL sweep_dbz a=%0d got dout=%0d rem=%0d ovf=%b dbz=%b",
                   a, dout, rem, ovf, dbz);
        end
      end else if (err) begin
        checks++;
        if (ovf !== 1'b1 || dbz !== 1'b0 || dout !== 13'h1FFF || rem !== 9'd0) begin
          failures++;
          $display("FAIL sweep_ovf a=%0d b=%0d got dout=%0d rem=%0d ovf=%b dbz=%b",
                   a, b, dout, rem, ovf, dbz);
        end
      end else begin
        recon = int'(dout) * int'(b) + int'(rem);
        checks++;
        if (recon !== int'(a) || rem >= b || ovf !== 1'b0 || dbz !== 1'b0) begin
          failures++;
          $display("FAIL sweep_div a=%0d b=%0d got dout=%0d rem=%0d ovf=%b dbz=%b",
                   a, b, dout, rem, ovf, dbz);
        end
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_quotient();
    test_overflow();
    test_div_by_zero();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
